// File: rtl/rvfi_pkg.sv
// Shared RVFI definitions: field widths, the flat entry layout, and pack/unpack
// helpers for every block that buffers RVFI retirements.
package rvfi_pkg;

  localparam int RVFI_XLEN   = 32;
  localparam int RVFI_REG_W  = 5;
  localparam int RVFI_INSN_W = 32;

  // Entry layout, MSB first: rs1, rs2, rd, insn, pre_pc, pre_rs1, pre_rs2, post_pc, post_rd, post_trap.
  localparam int RVFI_ENTRY_W    = 3 * RVFI_REG_W + RVFI_INSN_W + 1 + 5 * RVFI_XLEN;
  localparam int OFF_POST_TRAP   = 0;
  localparam int OFF_POST_RD     = OFF_POST_TRAP + 1;
  localparam int OFF_POST_PC     = OFF_POST_RD + RVFI_XLEN;
  localparam int OFF_PRE_RS2     = OFF_POST_PC + RVFI_XLEN;
  localparam int OFF_PRE_RS1     = OFF_PRE_RS2 + RVFI_XLEN;
  localparam int OFF_PRE_PC      = OFF_PRE_RS1 + RVFI_XLEN;
  localparam int OFF_INSN        = OFF_PRE_PC + RVFI_XLEN;
  localparam int OFF_RD          = OFF_INSN + RVFI_INSN_W;
  localparam int OFF_RS2         = OFF_RD + RVFI_REG_W;
  localparam int OFF_RS1         = OFF_RS2 + RVFI_REG_W;

  typedef logic [RVFI_ENTRY_W-1:0] rvfi_vec_t;

  typedef struct packed {
    logic [RVFI_REG_W-1:0]  rs1;
    logic [RVFI_REG_W-1:0]  rs2;
    logic [RVFI_REG_W-1:0]  rd;
    logic [RVFI_INSN_W-1:0] insn;
    logic [RVFI_XLEN-1:0]   pre_pc;
    logic [RVFI_XLEN-1:0]   pre_rs1;
    logic [RVFI_XLEN-1:0]   pre_rs2;
    logic [RVFI_XLEN-1:0]   post_pc;
    logic [RVFI_XLEN-1:0]   post_rd;
    logic                   post_trap;
  } rvfi_entry_t;

  function automatic rvfi_vec_t rvfi_pack(input rvfi_entry_t e);
    rvfi_vec_t v;
    v = '0;
    v[OFF_RS1       +: RVFI_REG_W]  = e.rs1;
    v[OFF_RS2       +: RVFI_REG_W]  = e.rs2;
    v[OFF_RD        +: RVFI_REG_W]  = e.rd;
    v[OFF_INSN      +: RVFI_INSN_W] = e.insn;
    v[OFF_PRE_PC    +: RVFI_XLEN]   = e.pre_pc;
    v[OFF_PRE_RS1   +: RVFI_XLEN]   = e.pre_rs1;
    v[OFF_PRE_RS2   +: RVFI_XLEN]   = e.pre_rs2;
    v[OFF_POST_PC   +: RVFI_XLEN]   = e.post_pc;
    v[OFF_POST_RD   +: RVFI_XLEN]   = e.post_rd;
    v[OFF_POST_TRAP]                = e.post_trap;
    return v;
  endfunction

  function automatic rvfi_entry_t rvfi_unpack(input rvfi_vec_t v);
    rvfi_entry_t e;
    e.rs1       = v[OFF_RS1     +: RVFI_REG_W];
    e.rs2       = v[OFF_RS2     +: RVFI_REG_W];
    e.rd        = v[OFF_RD      +: RVFI_REG_W];
    e.insn      = v[OFF_INSN    +: RVFI_INSN_W];
    e.pre_pc    = v[OFF_PRE_PC  +: RVFI_XLEN];
    e.pre_rs1   = v[OFF_PRE_RS1 +: RVFI_XLEN];
    e.pre_rs2   = v[OFF_PRE_RS2 +: RVFI_XLEN];
    e.post_pc   = v[OFF_POST_PC +: RVFI_XLEN];
    e.post_rd   = v[OFF_POST_RD +: RVFI_XLEN];
    e.post_trap = v[OFF_POST_TRAP];
    return e;
  endfunction

endpackage

// File: rtl/rvfi_channel_serializer_if.sv
// Multi-channel RVFI input bundle plus the single-channel serialized output.
interface rvfi_channel_serializer_if #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*5-1:0]    rvfi_rs1;
  logic [NRET*5-1:0]    rvfi_rs2;
  logic [NRET*5-1:0]    rvfi_rd;
  logic [NRET*32-1:0]   rvfi_insn;
  logic [NRET*XLEN-1:0] rvfi_pre_pc;
  logic [NRET*XLEN-1:0] rvfi_pre_rs1;
  logic [NRET*XLEN-1:0] rvfi_pre_rs2;
  logic [NRET*XLEN-1:0] rvfi_post_pc;
  logic [NRET*XLEN-1:0] rvfi_post_rd;
  logic [NRET-1:0]      rvfi_post_trap;

  logic                 ser_ready;
  logic                 ser_valid;
  logic [4:0]           ser_rs1;
  logic [4:0]           ser_rs2;
  logic [4:0]           ser_rd;
  logic [31:0]          ser_insn;
  logic [XLEN-1:0]      ser_pre_pc;
  logic [XLEN-1:0]      ser_pre_rs1;
  logic [XLEN-1:0]      ser_pre_rs2;
  logic [XLEN-1:0]      ser_post_pc;
  logic [XLEN-1:0]      ser_post_rd;
  logic                 ser_post_trap;
  logic [OCC_W-1:0]     occupancy;
  logic                 overflow;

  modport master (
    output rvfi_valid, rvfi_rs1, rvfi_rs2, rvfi_rd, rvfi_insn, rvfi_pre_pc,
           rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd, rvfi_post_trap,
           ser_ready,
    input  ser_valid, ser_rs1, ser_rs2, ser_rd, ser_insn, ser_pre_pc, ser_pre_rs1,
           ser_pre_rs2, ser_post_pc, ser_post_rd, ser_post_trap, occupancy, overflow
  );

  modport slave (
    input  rvfi_valid, rvfi_rs1, rvfi_rs2, rvfi_rd, rvfi_insn, rvfi_pre_pc,
           rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd, rvfi_post_trap,
           ser_ready,
    output ser_valid, ser_rs1, ser_rs2, ser_rd, ser_insn, ser_pre_pc, ser_pre_rs1,
           ser_pre_rs2, ser_post_pc, ser_post_rd, ser_post_trap, occupancy, overflow
  );
endinterface

// File: rtl/rvfi_ser_fifo.sv
// Circular buffer of packed RVFI entries: up to NRET writes per cycle at
// consecutive wrapped addresses, one read per cycle. DEPTH must be a power of two >= 2.
module rvfi_ser_fifo
  import rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  localparam int OCC_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OCC_W-1:0] i_push_cnt,
  input  rvfi_vec_t        i_wdata [NRET],
  input  logic             i_pop,
  output rvfi_vec_t        o_rdata,
  output logic             o_valid,
  output logic [OCC_W-1:0] o_occ
);

  rvfi_vec_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  // NOTE: storage has no reset; occupancy alone decides what is visible, so stale words never leak out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NRET; k++) begin
        if (OCC_W'(k) < i_push_cnt) r_mem[r_wr_ptr + PTR_W'(k)] <= i_wdata[k];
      end
    end
  end

  // NOTE: reset is synchronous and wins over every push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_occ    <= r_occ + i_push_cnt - OCC_W'(i_pop);
    end
  end

  assign o_valid = (r_occ != '0);
  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_occ   = r_occ;

endmodule

// File: rtl/rvfi_channel_serializer.sv
// Compacts up to NRET retirements per cycle into a FIFO and replays them one per
// cycle in program order; any retirement that does not fit sets a sticky overflow.
module rvfi_channel_serializer
  import rvfi_pkg::*;
#(
  parameter int XLEN  = RVFI_XLEN,  // must equal RVFI_XLEN, the packed entry width depends on it
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input logic                     clk,
  input logic                     reset,
  rvfi_channel_serializer_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  rvfi_vec_t        w_chan [NRET];
  rvfi_vec_t        w_cmp  [NRET];
  logic [OCC_W-1:0] w_prefix [NRET];
  logic [NRET-1:0]  w_accept;
  logic [OCC_W-1:0] w_total;
  logic [OCC_W-1:0] w_free;
  logic [OCC_W-1:0] w_acc_cnt;
  logic             w_drop;
  logic             w_pop;
  logic             w_fifo_valid;
  logic [OCC_W-1:0] w_occ;
  rvfi_vec_t        w_head;
  rvfi_entry_t      w_head_e;
  logic             r_overflow;

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      w_chan[i] = rvfi_pack('{
        rs1:       bus.rvfi_rs1[i*RVFI_REG_W +: RVFI_REG_W],
        rs2:       bus.rvfi_rs2[i*RVFI_REG_W +: RVFI_REG_W],
        rd:        bus.rvfi_rd[i*RVFI_REG_W +: RVFI_REG_W],
        insn:      bus.rvfi_insn[i*RVFI_INSN_W +: RVFI_INSN_W],
        pre_pc:    bus.rvfi_pre_pc[i*XLEN +: XLEN],
        pre_rs1:   bus.rvfi_pre_rs1[i*XLEN +: XLEN],
        pre_rs2:   bus.rvfi_pre_rs2[i*XLEN +: XLEN],
        post_pc:   bus.rvfi_post_pc[i*XLEN +: XLEN],
        post_rd:   bus.rvfi_post_rd[i*XLEN +: XLEN],
        post_trap: bus.rvfi_post_trap[i]
      });
    end
  end

  assign w_pop  = w_fifo_valid & bus.ser_ready;
  // A same-cycle pop frees its slot for this cycle's pushes.
  assign w_free = OCC_W'(DEPTH) - w_occ + OCC_W'(w_pop);

  // Prefix count: channel i lands at slot (valid channels below i); only the first w_free fit.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments, each output defaulted first so no latch forms.
    w_total  = '0;
    w_accept = '0;
    for (int i = 0; i < NRET; i++) begin
      w_prefix[i] = w_total;
      w_accept[i] = bus.rvfi_valid[i] && (w_total < w_free);
      w_total     = w_total + OCC_W'(bus.rvfi_valid[i]);
    end
    w_drop    = (w_total > w_free);
    w_acc_cnt = w_drop ? w_free : w_total;
  end

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      w_cmp[k] = '0;
      for (int i = 0; i < NRET; i++) begin
        if (w_accept[i] && (w_prefix[i] == OCC_W'(k))) w_cmp[k] = w_chan[i];
      end
    end
  end

  rvfi_ser_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_cnt (w_acc_cnt),
    .i_wdata    (w_cmp),
    .i_pop      (w_pop),
    .o_rdata    (w_head),
    .o_valid    (w_fifo_valid),
    .o_occ      (w_occ)
  );

  always_ff @(posedge clk) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign w_head_e          = rvfi_unpack(w_head);
  assign bus.ser_valid     = w_fifo_valid;
  assign bus.ser_rs1       = w_head_e.rs1;
  assign bus.ser_rs2       = w_head_e.rs2;
  assign bus.ser_rd        = w_head_e.rd;
  assign bus.ser_insn      = w_head_e.insn;
  assign bus.ser_pre_pc    = w_head_e.pre_pc;
  assign bus.ser_pre_rs1   = w_head_e.pre_rs1;
  assign bus.ser_pre_rs2   = w_head_e.pre_rs2;
  assign bus.ser_post_pc   = w_head_e.post_pc;
  assign bus.ser_post_rd   = w_head_e.post_rd;
  assign bus.ser_post_trap = w_head_e.post_trap;
  assign bus.occupancy     = w_occ;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// Randomized and directed bench for rvfi_channel_serializer: a queue model predicts
// accepted retirements; a negedge monitor compares the head and status against it.
module tb_rvfi_channel_serializer;

  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     insn;
    logic [XLEN-1:0] pre_pc;
    logic [XLEN-1:0] pre_rs1;
    logic [XLEN-1:0] pre_rs2;
    logic [XLEN-1:0] post_pc;
    logic [XLEN-1:0] post_rd;
    logic            trap;
  } ret_t;

  typedef ret_t ret_arr_t [NRET];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rvfi_channel_serializer_if #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) bus ();

  rvfi_channel_serializer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  ret_t sb_q[$];
  int   exp_occ  = 0;
  bit   exp_ovf  = 1'b0;
  bit   running  = 1'b0;
  logic [31:0] next_pc = 32'h2000;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ret_t rand_ret(input logic [31:0] pc);
    ret_t r;
    r.rs1     = 5'($urandom);
    r.rs2     = 5'($urandom);
    r.rd      = 5'($urandom);
    r.insn    = $urandom;
    r.pre_pc  = pc;
    r.pre_rs1 = $urandom;
    r.pre_rs2 = $urandom;
    r.post_pc = pc + 32'd4;
    r.post_rd = $urandom;
    r.trap    = 1'($urandom);
    return r;
  endfunction

  function automatic ret_t dut_head();
    ret_t r;
    r.rs1     = bus.ser_rs1;
    r.rs2     = bus.ser_rs2;
    r.rd      = bus.ser_rd;
    r.insn    = bus.ser_insn;
    r.pre_pc  = bus.ser_pre_pc;
    r.pre_rs1 = bus.ser_pre_rs1;
    r.pre_rs2 = bus.ser_pre_rs2;
    r.post_pc = bus.ser_post_pc;
    r.post_rd = bus.ser_post_rd;
    r.trap    = bus.ser_post_trap;
    return r;
  endfunction

  task automatic drive_inputs(input logic [NRET-1:0] v, input logic rdy, input ret_arr_t ch);
    bus.rvfi_valid = v;
    bus.ser_ready  = rdy;
    for (int i = 0; i < NRET; i++) begin
      bus.rvfi_rs1[i*5 +: 5]          = ch[i].rs1;
      bus.rvfi_rs2[i*5 +: 5]          = ch[i].rs2;
      bus.rvfi_rd[i*5 +: 5]           = ch[i].rd;
      bus.rvfi_insn[i*32 +: 32]       = ch[i].insn;
      bus.rvfi_pre_pc[i*XLEN +: XLEN] = ch[i].pre_pc;
      bus.rvfi_pre_rs1[i*XLEN +: XLEN] = ch[i].pre_rs1;
      bus.rvfi_pre_rs2[i*XLEN +: XLEN] = ch[i].pre_rs2;
      bus.rvfi_post_pc[i*XLEN +: XLEN] = ch[i].post_pc;
      bus.rvfi_post_rd[i*XLEN +: XLEN] = ch[i].post_rd;
      bus.rvfi_post_trap[i]           = ch[i].trap;
    end
  endtask

  // One clock cycle: apply inputs, predict acceptance from queue occupancy, advance.
  task automatic step(input logic [NRET-1:0] v, input logic rdy, input ret_arr_t ch);
    int pop;
    int free;
    int acc;
    bit nxt_ovf;
    drive_inputs(v, rdy, ch);
    pop     = (exp_occ > 0 && rdy) ? 1 : 0;
    free    = DEPTH - exp_occ + pop;
    acc     = 0;
    nxt_ovf = exp_ovf;
    for (int i = 0; i < NRET; i++) begin
      if (v[i]) begin
        if (acc < free) begin
          sb_q.push_back(ch[i]);
          acc++;
        end else begin
          nxt_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    exp_occ = exp_occ + acc - pop;
    exp_ovf = nxt_ovf;
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    ret_arr_t ch;
    for (int i = 0; i < NRET; i++) ch[i] = '0;
    for (int c = 0; c < n; c++) step('0, rdy, ch);
  endtask

  task automatic mk_pair(input logic [31:0] pc0, input logic [31:0] pc1, output ret_arr_t ch);
    ch[0] = rand_ret(pc0);
    ch[1] = rand_ret(pc1);
  endtask

  task automatic do_reset();
    ret_arr_t ch;
    mk_pair(32'hdead0000, 32'hdead0004, ch);
    drive_inputs('1, 1'b1, ch);
    reset = 1'b1;
    @(posedge clk);
    sb_q.delete();
    exp_occ = 0;
    exp_ovf = 1'b0;
    #1;
    reset = 1'b0;
    bus.rvfi_valid = '0;
  endtask

  // Monitor: compares the presented head and status against the model every cycle.
  always @(negedge clk) begin
    if (running) begin
      check("occupancy", bus.occupancy, exp_occ);
      check("overflow", bus.overflow, exp_ovf);
      check("ser_valid", bus.ser_valid, exp_occ != 0);
      if (exp_occ != 0) begin
        if (sb_q.size() == 0) begin
          check("head_available", 0, 1);
        end else begin
          check("head", dut_head(), sb_q[0]);
          if (bus.ser_ready) void'(sb_q.pop_front());
        end
      end else begin
        check("idle_data_zero", dut_head(), '0);
      end
    end
  end

  initial begin
    ret_arr_t ch;
    drive_inputs('0, 1'b0, '{default: '0});
    repeat (2) @(posedge clk);
    running = 1'b1;
    #1;
    reset = 1'b0;

    check("rst_occ", bus.occupancy, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_valid", bus.ser_valid, 0);

    // Single retire with one-cycle latency.
    mk_pair(32'h100, 32'h0, ch);
    ch[0].insn = 32'h0000_0013;
    step(2'b01, 1'b1, ch);
    check("t1_valid", bus.ser_valid, 1);
    check("t1_insn", bus.ser_insn, 32'h13);
    check("t1_pc", bus.ser_pre_pc, 32'h100);
    idle(1'b1, 1);
    check("t1_empty_valid", bus.ser_valid, 0);
    check("t1_empty_occ", bus.occupancy, 0);

    // Order and compaction.
    mk_pair(32'h200, 32'h204, ch);
    step(2'b11, 1'b1, ch);
    check("t2_pc0", bus.ser_pre_pc, 32'h200);
    mk_pair(32'h0, 32'h208, ch);
    step(2'b10, 1'b1, ch);
    check("t2_pc1", bus.ser_pre_pc, 32'h204);
    idle(1'b1, 1);
    check("t2_pc2", bus.ser_pre_pc, 32'h208);
    idle(1'b1, 1);

    // Fill, then overflow with both channels dropped.
    for (int c = 0; c < 4; c++) begin
      mk_pair(32'h400 + 32'(c * 8), 32'h404 + 32'(c * 8), ch);
      step(2'b11, 1'b0, ch);
    end
    check("t3_full_occ", bus.occupancy, 8);
    check("t3_full_ovf", bus.overflow, 0);
    mk_pair(32'h500, 32'h504, ch);
    step(2'b11, 1'b0, ch);
    check("t3_drop_occ", bus.occupancy, 8);
    check("t3_drop_ovf", bus.overflow, 1);

    // Push and pop while full: only ch0 fits.
    mk_pair(32'h600, 32'h604, ch);
    step(2'b11, 1'b1, ch);
    check("t4_occ", bus.occupancy, 8);
    check("t4_ovf", bus.overflow, 1);
    idle(1'b1, 7);
    check("t4_last_pc", bus.ser_pre_pc, 32'h600);
    idle(1'b1, 1);
    check("t4_drained", bus.occupancy, 0);

    // Backpressure holds the head stable.
    mk_pair(32'h300, 32'h304, ch);
    step(2'b11, 1'b0, ch);
    for (int c = 0; c < 3; c++) begin
      idle(1'b0, 1);
      check("t5_hold_pc", bus.ser_pre_pc, 32'h300);
    end
    idle(1'b1, 1);
    check("t5_next_pc", bus.ser_pre_pc, 32'h304);
    idle(1'b1, 1);

    // Reset mid-stream, then wrap the pointers with single pushes and pops.
    mk_pair(32'h700, 32'h704, ch);
    step(2'b11, 1'b0, ch);
    mk_pair(32'h708, 32'h70c, ch);
    step(2'b11, 1'b0, ch);
    mk_pair(32'h710, 32'h0, ch);
    step(2'b01, 1'b0, ch);
    check("t6_pre_occ", bus.occupancy, 5);
    check("t6_pre_ovf", bus.overflow, 1);
    do_reset();
    check("t6_rst_occ", bus.occupancy, 0);
    check("t6_rst_ovf", bus.overflow, 0);
    check("t6_rst_valid", bus.ser_valid, 0);
    check("t6_rst_pc", bus.ser_pre_pc, 0);
    for (int k = 0; k < 20; k++) begin
      mk_pair(32'h1000 + 32'(k * 4), 32'h0, ch);
      step(2'b01, 1'b1, ch);
      check("t6_wrap_pc", bus.ser_pre_pc, 32'h1000 + 32'(k * 4));
    end
    idle(1'b1, 1);

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      mk_pair(next_pc, next_pc + 32'd4, ch);
      next_pc = next_pc + 32'd8;
      step(NRET'($urandom), ($urandom_range(0, 3) != 0), ch);
    end
    idle(1'b1, DEPTH + 1);
    check("final_occ", bus.occupancy, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvfi_channel_serializer.md
# rvfi_channel_serializer

Buffers up to NRET RVFI retirements per cycle from a multi-retire core and replays them one per cycle, in program order, on a single RVFI channel. Sits directly upstream of the instruction checker built with NRET=1. The checker, which looks at one channel, therefore sees every retirement of a superscalar core. Drops are never silent: a sticky overflow flag reports them.

## Interface
- XLEN, 32: register/PC width.
- NRET, 2: input retirement channels; 1..8.
- DEPTH, 8: FIFO entries; power of two, DEPTH >= NRET.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rvfi_valid  in  NRET  per-channel retire strobe.
- rvfi_rs1 / rvfi_rs2 / rvfi_rd  in  NRET*5 each  register indices.
- rvfi_insn  in  NRET*32  instruction word.
- rvfi_pre_pc / rvfi_pre_rs1 / rvfi_pre_rs2 / rvfi_post_pc / rvfi_post_rd  in  NRET*XLEN each  channel fields.
- rvfi_post_trap  in  NRET  trap flag.
- ser_ready  in  1  consumer accepts the head entry; tie 1 for the checker.
- ser_valid  out  1  head entry present.
- ser_rs1, ser_rs2, ser_rd, ser_insn, ser_pre_pc, ser_pre_rs1, ser_pre_rs2, ser_post_pc, ser_post_rd, ser_post_trap  out  single-channel widths  head entry fields.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky; set when any valid channel was dropped.

## Operation
- Entry layout: rs1, rs2, rd, insn, pre_pc, pre_rs1, pre_rs2, post_pc, post_rd, post_trap. Width is 48+5*XLEN bits.
- Enqueue compacts the valid channels in ascending channel index. Channel i precedes channel j when i<j, and gaps from invalid channels are skipped. Example: valid=4'b1010 enqueues ch1 then ch3.
- Pop condition: ser_valid && ser_ready. The head advances by one.
- Free space for the cycle is DEPTH - occupancy + pop. A simultaneous pop frees its slot for the same-cycle push.
- Number accepted = min(popcount(rvfi_valid), free). The lowest-index valid channels are accepted and the rest are dropped.
- overflow sets on any drop. It clears only on reset.
- Pointers wrap modulo DEPTH.
- occupancy_next = occupancy + accepted - pop.
- Full: occupancy==DEPTH. With no pop, every valid channel drops.
- Empty: ser_valid=0, and all ser_* data outputs are driven 0.
- Reset mid-operation empties the FIFO and discards its contents. Inputs in the reset cycle are ignored.

## Timing
- Reset values: ser_valid=0, ser_* data=0, occupancy=0, overflow=0, read and write pointers=0.
- Latency: a retirement presented in cycle N is visible on ser_* at cycle N+1 at the earliest, when the FIFO was empty. Otherwise it follows all older entries.
- ser_* outputs are driven from registered storage/pointers only. There is no combinational path from rvfi_* to ser_*.
- Throughput: one pop per cycle maximum. Sustained input above one retirement per cycle fills the FIFO at the rate popcount-1.
- ser_* stays stable while ser_valid && !ser_ready.

## Structure
- Shared package rvfi_pkg holds:
  - RVFI field width constants (5, 32, XLEN-derived);
  - entry width and field offset localparams;
  - a pack function and an unpack function used by this block and any future RVFI buffering blocks.
- Sub-module rvfi_ser_fifo: DEPTH x entry-width storage, multi-write port (up to NRET writes at consecutive wrapped addresses), single read port, pointers, occupancy.
- Top level holds the compaction/prefix-count logic, the accept limiter and the overflow flag.

## Test plan
- Single retire: NRET=2, cycle 0 valid=2'b01, insn=0x00000013, pc=0x100 -> cycle 1 ser_valid=1, ser_insn=0x13, ser_pre_pc=0x100; cycle 2 ser_valid=0, occupancy=0.
- Order/compaction: cycle 0 valid=2'b11 (ch0 pc=0x200, ch1 pc=0x204); cycle 1 valid=2'b10 (ch1 pc=0x208) -> ser_pre_pc = 0x200, 0x204, 0x208 on cycles 1, 2, 3.
- Fill and overflow: ser_ready=0, valid=2'b11 for 4 cycles -> occupancy=8, overflow=0; 5th cycle -> occupancy=8, overflow=1, both entries dropped.
- Simultaneous push/pop at full: occupancy=8, ser_ready=1, valid=2'b11 -> ch0 accepted, ch1 dropped, occupancy stays 8, overflow=1.
- Backpressure stability: head pc=0x300, ser_ready=0 for 3 cycles -> ser_* unchanged; ser_ready=1 -> next entry next cycle.
- Reset mid-stream: occupancy=5, overflow=1, reset=1 with valid=2'b11 -> next cycle all outputs 0; pointer wrap verified afterwards by 20 single pushes and pops with the PC sequence intact.
